// File: rtl/ddr_tx_pkg.sv
// Shared types and line levels for the dual-edge transmit sequencer.
package ddr_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        SHIFT = 2'd2,
        POST  = 2'd3
    } state_e;

    localparam logic PRE_HI   = 1'b1;
    localparam logic PRE_LO   = 1'b0;
    localparam logic POST_LVL = 1'b0;

    // Pair counter width; a single-pair word still needs one bit.
    function automatic int cnt_width(input int pairs);
        return (pairs > 1) ? $clog2(pairs) : 1;
    endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// Dual-edge output cell: rising- and falling-edge registers XOR-combined
// so q follows d_rise after the rising edge and d_fall after the falling edge.
module ddr_out_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d_rise,
    input  logic d_fall,
    output logic q
);

    logic rise_q;
    logic fall_q;
    logic en_fall_q;

    // en is captured at the rising edge so the following falling edge obeys
    // the same freeze decision even if en moves mid-cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q    <= 1'b0;
            en_fall_q <= 1'b0;
        end else begin
            en_fall_q <= en;
            if (en) begin
                rise_q <= d_rise ^ fall_q;
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fall_q <= 1'b0;
        end else if (en_fall_q) begin
            fall_q <= d_fall ^ rise_q;
        end
    end

    assign q = rise_q ^ fall_q;

endmodule

// File: rtl/ddr_tx_sequencer.sv
// Frames accepted words as PRE / SHIFT... / POST bursts and drives two bits
// per clock through the dual-edge output cell, LSB first.
module ddr_tx_sequencer
    import ddr_tx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    input  logic             stall,
    output logic             tx_q,
    output logic             tx_oe,
    output logic             tx_frame,
    output logic             done
);

    localparam int PAIRS = WIDTH / 2;
    localparam int CW    = cnt_width(PAIRS);
    localparam logic [CW-1:0] LAST_CNT = CW'(PAIRS - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic             fall_q;
    logic             oe_q;
    logic             frame_q;
    logic             done_q;

    logic last_pair;
    logic accept;
    logic rise_d;
    logic fall_d;
    logic cell_en;

    always_comb begin
        last_pair = (state_q == SHIFT) && (cnt_q == LAST_CNT);
        s_ready   = rst_n && !stall && ((state_q == IDLE) || last_pair);
        accept    = s_valid && s_ready;
        cell_en   = !stall;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        case (state_q)
            PRE: begin
                rise_d = PRE_HI;
                fall_d = PRE_LO;
            end
            SHIFT: begin
                rise_d = shift_q[0];
                fall_d = shift_q[1];
            end
            POST: begin
                rise_d = POST_LVL;
                fall_d = POST_LVL;
            end
            default: begin
                rise_d = 1'b0;
                fall_d = 1'b0;
            end
        endcase
    end

    // The phase values for the state in this cycle are launched at the next
    // rising edge, so tx_oe/tx_frame are registered alongside to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            fall_q  <= 1'b0;
            oe_q    <= 1'b0;
            frame_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (stall) begin
            done_q <= 1'b0;
        end else begin
            oe_q    <= (state_q != IDLE);
            frame_q <= (state_q == SHIFT);
            fall_q  <= fall_d;
            done_q  <= last_pair && !accept;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= PRE;
                        shift_q <= s_data;
                        cnt_q   <= '0;
                    end
                end
                PRE: begin
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (last_pair) begin
                        if (accept) begin
                            shift_q <= s_data;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= POST;
                        end
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                        shift_q <= shift_q >> 2;
                    end
                end
                POST: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    ddr_out_cell u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (cell_en),
        .d_rise (rise_d),
        .d_fall (fall_q),
        .q      (tx_q)
    );

    assign tx_oe    = oe_q;
    assign tx_frame = frame_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Directed vector bench for ddr_tx_sequencer (WIDTH=8 and WIDTH=2 instances).
module tb_ddr_tx_sequencer;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;

    logic       valid8 = 1'b0;
    logic [7:0] data8  = '0;
    logic       stall8 = 1'b0;
    logic       rdy8, q8, oe8, fr8, dn8;

    logic       valid2 = 1'b0;
    logic [1:0] data2  = '0;
    logic       stall2 = 1'b0;
    logic       rdy2, q2, oe2, fr2, dn2;

    always #5 clk = ~clk;

    ddr_tx_sequencer #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .s_valid(valid8), .s_data(data8),
        .s_ready(rdy8), .stall(stall8), .tx_q(q8), .tx_oe(oe8),
        .tx_frame(fr8), .done(dn8)
    );

    ddr_tx_sequencer #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(valid2), .s_data(data2),
        .s_ready(rdy2), .stall(stall2), .tx_q(q2), .tx_oe(oe2),
        .tx_frame(fr2), .done(dn2)
    );

    // exp = {s_ready before the edge, tx_q high phase, tx_q low phase, tx_oe, tx_frame, done}
    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       stall;
        logic [5:0] exp;
    } vec_t;

    vec_t  tbl[$];
    int    tests = 0;
    int    fails = 0;
    string seg   = "init";

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic s, input logic [5:0] e);
        vec_t x;
        x.valid = v;
        x.data  = d;
        x.stall = s;
        x.exp   = e;
        return x;
    endfunction

    task automatic add(input logic v, input logic [7:0] d, input logic s, input logic [5:0] e);
        tbl.push_back(mk(v, d, s, e));
    endtask

    task automatic chk(input string name, input int row, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s %s row %0d: got %0b want %0b", seg, name, row, act, exp);
        end
    endtask

    // Entered 6 time units after a rising edge; leaves at the same offset one cycle later.
    task automatic step(input vec_t v, input bit sel, input int row);
        logic rdy, hi, lo, oe, fr, dn;
        if (!sel) begin
            valid8 = v.valid; data8 = v.data; stall8 = v.stall;
        end else begin
            valid2 = v.valid; data2 = v.data[1:0]; stall2 = v.stall;
        end
        #1;
        rdy = sel ? rdy2 : rdy8;
        @(posedge clk);
        #1;
        hi = sel ? q2  : q8;
        oe = sel ? oe2 : oe8;
        fr = sel ? fr2 : fr8;
        dn = sel ? dn2 : dn8;
        #5;
        lo = sel ? q2 : q8;
        chk("s_ready",  row, rdy, v.exp[5]);
        chk("tx_q_hi",  row, hi,  v.exp[4]);
        chk("tx_q_lo",  row, lo,  v.exp[3]);
        chk("tx_oe",    row, oe,  v.exp[2]);
        chk("tx_frame", row, fr,  v.exp[1]);
        chk("done",     row, dn,  v.exp[0]);
        $display("[TB] %s row %0d v=%0b d=%02h st=%0b -> rdy=%0b q=(%0b,%0b) oe=%0b fr=%0b done=%0b",
                 seg, row, v.valid, v.data, v.stall, rdy, hi, lo, oe, fr, dn);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // single word 0xA5: pairs (1,0),(1,0),(0,1),(0,1)
        add(1, 8'hA5, 0, 6'b100000);
        add(0, 8'h00, 0, 6'b010100);
        add(0, 8'h00, 0, 6'b010110);
        add(0, 8'h00, 0, 6'b010110);
        add(0, 8'h00, 0, 6'b001110);
        add(0, 8'h00, 0, 6'b101111);
        add(0, 8'h00, 0, 6'b000100);
        add(0, 8'h00, 0, 6'b100000);
        // 0x0F then 0xF0 back-to-back, s_valid held through PRE and SHIFT
        add(1, 8'h0F, 0, 6'b100000);
        add(1, 8'hF0, 0, 6'b010100);
        add(1, 8'hF0, 0, 6'b011110);
        add(1, 8'hF0, 0, 6'b011110);
        add(1, 8'hF0, 0, 6'b000110);
        add(1, 8'hF0, 0, 6'b100110);
        add(0, 8'h00, 0, 6'b000110);
        add(0, 8'h00, 0, 6'b000110);
        add(0, 8'h00, 0, 6'b011110);
        add(0, 8'h00, 0, 6'b111111);
        add(0, 8'h00, 0, 6'b000100);
        add(0, 8'h00, 0, 6'b100000);
        // 0x3C with a 3-cycle stall in SHIFT cycle 1
        add(1, 8'h3C, 0, 6'b100000);
        add(0, 8'h00, 0, 6'b010100);
        add(0, 8'h00, 0, 6'b000110);
        add(0, 8'h00, 1, 6'b000110);
        add(0, 8'h00, 1, 6'b000110);
        add(0, 8'h00, 1, 6'b000110);
        add(0, 8'h00, 0, 6'b011110);
        add(0, 8'h00, 0, 6'b011110);
        add(0, 8'h00, 0, 6'b100111);
        add(0, 8'h00, 0, 6'b000100);
        add(0, 8'h00, 0, 6'b100000);
        // stall in IDLE blocks the accept
        add(1, 8'h55, 1, 6'b000000);
        add(0, 8'h00, 0, 6'b100000);
        add(0, 8'h00, 0, 6'b100000);
        // 0xC3, then s_valid during POST with 0x5A: accepted only in IDLE
        add(1, 8'hC3, 0, 6'b100000);
        add(0, 8'h00, 0, 6'b010100);
        add(0, 8'h00, 0, 6'b011110);
        add(0, 8'h00, 0, 6'b000110);
        add(0, 8'h00, 0, 6'b000110);
        add(0, 8'h00, 0, 6'b111111);
        add(1, 8'h5A, 0, 6'b000100);
        add(1, 8'h5A, 0, 6'b100000);
        add(0, 8'h00, 0, 6'b010100);
        add(0, 8'h00, 0, 6'b001110);
        add(0, 8'h00, 0, 6'b001110);
        add(0, 8'h00, 0, 6'b010110);
        add(0, 8'h00, 0, 6'b110111);
        add(0, 8'h00, 0, 6'b000100);
        add(0, 8'h00, 0, 6'b100000);

        // reset state, with s_valid high to show s_ready stays low
        valid8 = 1'b1;
        #23;
        seg = "reset";
        chk("s_ready", 0, rdy8, 1'b0);
        chk("tx_q",    0, q8,   1'b0);
        chk("tx_oe",   0, oe8,  1'b0);
        chk("tx_frame",0, fr8,  1'b0);
        chk("done",    0, dn8,  1'b0);
        chk("tx_q_w2", 0, q2,   1'b0);
        #4;
        valid8 = 1'b0;
        rst_n  = 1'b1;
        @(posedge clk);
        #6;

        seg = "w8_table";
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b0, i);
        end

        // reset in the middle of SHIFT of 0xFF, then 0x01 from a fresh PRE
        seg = "w8_midreset";
        step(mk(1, 8'hFF, 0, 6'b100000), 1'b0, 0);
        step(mk(0, 8'h00, 0, 6'b010100), 1'b0, 1);
        step(mk(0, 8'h00, 0, 6'b011110), 1'b0, 2);
        rst_n = 1'b0;
        #1;
        chk("async_tx_q",     3, q8,   1'b0);
        chk("async_tx_oe",    3, oe8,  1'b0);
        chk("async_tx_frame", 3, fr8,  1'b0);
        chk("async_s_ready",  3, rdy8, 1'b0);
        #12;
        chk("held_tx_q",      4, q8,   1'b0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #6;
        step(mk(1, 8'h01, 0, 6'b100000), 1'b0, 5);
        step(mk(0, 8'h00, 0, 6'b010100), 1'b0, 6);
        step(mk(0, 8'h00, 0, 6'b010110), 1'b0, 7);
        step(mk(0, 8'h00, 0, 6'b000110), 1'b0, 8);
        step(mk(0, 8'h00, 0, 6'b000110), 1'b0, 9);
        step(mk(0, 8'h00, 0, 6'b100111), 1'b0, 10);
        step(mk(0, 8'h00, 0, 6'b000100), 1'b0, 11);
        step(mk(0, 8'h00, 0, 6'b100000), 1'b0, 12);

        // WIDTH=2 streaming: every SHIFT cycle is the last one
        seg = "w2_stream";
        step(mk(1, 8'h02, 0, 6'b100000), 1'b1, 0);
        step(mk(1, 8'h01, 0, 6'b010100), 1'b1, 1);
        step(mk(1, 8'h01, 0, 6'b101110), 1'b1, 2);
        step(mk(1, 8'h02, 0, 6'b110110), 1'b1, 3);
        step(mk(0, 8'h00, 0, 6'b101111), 1'b1, 4);
        step(mk(0, 8'h00, 0, 6'b000100), 1'b1, 5);
        step(mk(0, 8'h00, 0, 6'b100000), 1'b1, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ddr_tx_sequencer.md
# ddr_tx_sequencer

Sequencer for a dual-edge-clocked serial output. It accepts parallel words over a valid/ready handshake and frames each burst with a preamble and a postamble. It drives two bits per clock cycle: the even bit is launched on the rising edge and the odd bit on the falling edge. It sits between a word-wide source and the pad-side dual-edge output cell, which it instantiates and owns.

## Interface
- WIDTH, 8, word width in bits; must be even and ≥ 2.
- clk  in  1  clock; both edges are used by the output cell, the FSM uses the rising edge only.
- rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  source word valid.
- s_data  in  WIDTH  source word, transmitted LSB first.
- s_ready  out  1  sequencer accepts the word at this rising edge.
- stall  in  1  freeze request: FSM, counter and output hold.
- tx_q  out  1  dual-edge serial data.
- tx_oe  out  1  output enable; high from preamble through postamble.
- tx_frame  out  1  high while data bits (SHIFT) are on tx_q.
- done  out  1  one-cycle pulse in the cycle after the last data cycle of a burst.

## Operation
- States:
  - IDLE
  - PRE: 1 cycle; tx_q = 1 in the high phase, 0 in the low phase.
  - SHIFT: WIDTH/2 cycles; cycle k carries bit 2k in the high phase and bit 2k+1 in the low phase.
  - POST: 1 cycle; tx_q = 0 in both phases.
- Transitions:
  - IDLE→PRE on accept.
  - PRE→SHIFT.
  - SHIFT→SHIFT (next word) when the last cycle of the word accepts a new word.
  - SHIFT→POST when the last cycle has no accept.
  - POST→IDLE. POST never accepts.
- Accept = s_valid && s_ready at a rising edge. The word is latched into a shift register at acceptance.
- s_ready = !stall && (state==IDLE || (state==SHIFT && last cycle of word)).
- Back-to-back words inside a burst have no preamble and no gap. The bit stream is continuous.
- Pair counter: $clog2(WIDTH/2) bits minimum, counts 0..WIDTH/2-1 and reloads 0 on a new word. WIDTH=2 means every SHIFT cycle is the last cycle.
- stall = 1 at a rising edge:
  - state, counter and shift register hold.
  - The output cell's enable is low, so tx_q holds its current value on both edges.
  - done is suppressed until the stall is released.
  - A stall in IDLE has no effect other than s_ready = 0.
- done pulses for exactly 1 cycle, while the FSM is in POST, and only once per burst. It does not pulse between back-to-back words.

## Timing
- Reset values:
  - state = IDLE, tx_q = 0, tx_oe = 0, tx_frame = 0, done = 0.
  - s_ready = 0 while rst_n is low.
- Reset mid-burst: outputs clear immediately and asynchronously, including both halves of the output cell. The in-flight word is discarded. After release the FSM is in IDLE.
- Accept at rising edge E0 (from IDLE):
  - PRE high phase appears at E0+1.
  - Bit 0 appears at E0+2.
  - Bit WIDTH-1 appears in the low phase of cycle E0+1+WIDTH/2.
  - POST occupies the cycle starting at E0+2+WIDTH/2.
- tx_oe and tx_frame change only at rising edges. tx_frame is aligned to SHIFT cycles.
- tx_q changes at both edges. The FSM launches the value for each phase from registered state only. There is no combinational path from s_data or s_valid to tx_q.
- Throughput: one word per WIDTH/2 cycles when streaming. The overhead per burst is 2 cycles.

## Structure
- Package `ddr_tx_pkg`: state enum (IDLE, PRE, SHIFT, POST), preamble pattern constants PRE_HI = 1 and PRE_LO = 0, and the POST level.
- Sub-module `ddr_out_cell`:
  - Inputs: clk, rst_n, en, d_rise, d_fall. Output: q.
  - A rising-edge register and a falling-edge register, XOR-combined so that q takes d_rise after the rising edge and d_fall after the falling edge.
  - With en low, both registers hold.
- The sequencer computes d_rise and d_fall from rising-edge registered state.

## Test plan
- WIDTH=8, single word 0xA5:
  - Expected tx_q phase pairs: PRE (1,0), then (1,0),(1,0),(0,1),(0,1), then POST (0,0).
  - tx_frame is high for 4 cycles, done pulses once, and tx_oe is high for 6 cycles.
- Stream 0x0F, 0xF0 back-to-back:
  - s_ready is high on the last SHIFT cycle of 0x0F.
  - 8 contiguous SHIFT cycles with no preamble between the words, then POST and a single done.
- Stall for 3 cycles in SHIFT cycle 1 of 0x3C:
  - tx_q is frozen at bit 1 (0) for the whole stall. The stream then resumes with pair (1,1).
  - The total burst length is 9 cycles.
- rst_n low in the middle of SHIFT:
  - tx_q, tx_oe and tx_frame are 0 within the reset assertion, with no clock edge needed.
  - After release, s_ready = 1 and the next word 0x01 starts with PRE.
- s_valid held high continuously with WIDTH=2 and data 0b10, 0b01:
  - Pairs (0,1),(1,0) with one accept per cycle.
  - POST only after s_valid drops.
- s_valid asserted during POST: no accept. The word is accepted in IDLE on the next cycle and a fresh PRE follows.
